instr_rom_banked: RTL and testbench

INSTR_ROM_BANKED -- requirements
Module: instr_rom_banked

---
 rtl/instr_rom_banked_pkg.sv | 26 ++
 rtl/instr_rom_banked_ram.sv | 32 +++
 rtl/instr_rom_banked.sv | 147 ++++++++++++++
 tb/tb_instr_rom_banked.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_rom_banked_pkg.sv
// Shared definitions for the banked instruction ROM: FSM encoding,
// instruction field positions and the NOP word.
package instr_rom_banked_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int FORMAT_BIT = 8;
    localparam int OPCODE_HI  = 7;
    localparam int OPCODE_LO  = 4;
    localparam int SIGN_BIT   = 3;
    localparam int OPERAND_HI = 2;
    localparam int OPERAND_LO = 0;
    localparam int IMM_HI     = 7;
    localparam int IMM_LO     = 0;

    localparam int NOP_WORD = 0;

    // Index width that never collapses to zero bits (BANKS=1 still gets a port bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instr_rom_banked_ram.sv
// Flat BANKS*DEPTH word array: one synchronous write port, one registered read port.
// No reset on the array; contents are only defined by what is written.
module instr_bank_ram #(
    parameter int INSTR_W = 9,
    parameter int WORDS   = 128,
    parameter int AW      = 7
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [WORDS];
    logic [INSTR_W-1:0] rdata_q;

    // Nonblocking read and write on the same edge give read-before-write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_rom_banked.sv
// Banked instruction memory: clears itself after reset, then accepts word
// loads and registered fetches decoded into instruction fields.
module instr_rom_banked
    import instr_rom_banked_pkg::*;
#(
    parameter int INSTR_W = 9,
    parameter int DEPTH   = 64,
    parameter int BANKS   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_en,
    input  logic [idx_w(BANKS)-1:0]   load_bank,
    input  logic [idx_w(DEPTH)-1:0]   load_addr,
    input  logic [INSTR_W-1:0]        load_data,
    input  logic                      fetch_req,
    input  logic [15:0]               pc_in,
    input  logic [idx_w(BANKS)-1:0]   bank_sel,
    input  logic                      stall,
    output logic                      busy,
    output logic                      instr_valid,
    output logic                      format,
    output logic [3:0]                opcode,
    output logic                      sign,
    output logic [2:0]                operand,
    output logic [7:0]                immediate,
    output logic [INSTR_W-1:0]        instr_raw,
    output logic                      range_err
);

    localparam int WORDS = BANKS * DEPTH;
    localparam int TW    = $clog2(WORDS);
    localparam int AW    = $clog2(DEPTH);
    localparam int LAST  = WORDS - 1;

    state_e          state_q, state_d;
    logic [TW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            instr_valid_q, instr_valid_d;
    logic            range_err_q, range_err_d;
    logic            zero_q, zero_d;

    logic               mem_we, mem_re;
    logic [TW-1:0]      mem_waddr, mem_raddr;
    logic [INSTR_W-1:0] mem_wdata, mem_rdata;
    logic               fetch_ok, in_range;

    // Bank index wraps modulo BANKS; storage is bank-major.
    function automatic logic [TW-1:0] flat(input int bank, input int addr);
        return TW'((bank % BANKS) * DEPTH + addr);
    endfunction

    assign in_range = (pc_in < 16'(DEPTH));
    assign fetch_ok = (state_q == ST_RUN) && fetch_req && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == TW'(LAST)) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_CLEAR);
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = INSTR_W'(NOP_WORD);
        end else begin
            mem_we    = load_en;
            mem_waddr = flat(int'(load_bank), int'(load_addr));
            mem_wdata = load_data;
        end
        mem_re    = fetch_ok && in_range;
        mem_raddr = flat(int'(bank_sel), int'(pc_in[AW-1:0]));
    end

    // zero_q masks the RAM output: set by reset and by out-of-range fetches.
    always_comb begin
        instr_valid_d = instr_valid_q;
        zero_d        = zero_q;
        range_err_d   = 1'b0;
        if (state_q != ST_RUN) begin
            instr_valid_d = 1'b0;
        end else if (!stall) begin
            instr_valid_d = fetch_req;
            if (fetch_req) begin
                zero_d      = !in_range;
                range_err_d = !in_range;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid_q <= 1'b0;
            range_err_q   <= 1'b0;
            zero_q        <= 1'b1;
        end else begin
            instr_valid_q <= instr_valid_d;
            range_err_q   <= range_err_d;
            zero_q        <= zero_d;
        end
    end

    instr_bank_ram #(
        .INSTR_W (INSTR_W),
        .WORDS   (WORDS),
        .AW      (TW)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign instr_raw   = zero_q ? INSTR_W'(NOP_WORD) : mem_rdata;
    assign instr_valid = instr_valid_q;
    assign range_err   = range_err_q;
    assign format      = instr_raw[FORMAT_BIT];
    assign opcode      = instr_raw[OPCODE_HI:OPCODE_LO];
    assign sign        = instr_raw[SIGN_BIT];
    assign operand     = instr_raw[OPERAND_HI:OPERAND_LO];
    assign immediate   = instr_raw[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_instr_rom_banked.sv
// Directed bench for instr_rom_banked with default parameters; expected
// fetch responses are queued by the driver and checked by a monitor.
module tb_instr_rom_banked;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic        load_bank;
    logic [5:0]  load_addr;
    logic [8:0]  load_data;
    logic        fetch_req;
    logic [15:0] pc_in;
    logic        bank_sel;
    logic        stall;
    logic        busy, instr_valid, format, sign, range_err;
    logic [3:0]  opcode;
    logic [2:0]  operand;
    logic [7:0]  immediate;
    logic [8:0]  instr_raw;

    logic [27:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    instr_rom_banked dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_bank   (load_bank),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .fetch_req   (fetch_req),
        .pc_in       (pc_in),
        .bank_sel    (bank_sel),
        .stall       (stall),
        .busy        (busy),
        .instr_valid (instr_valid),
        .format      (format),
        .opcode      (opcode),
        .sign        (sign),
        .operand     (operand),
        .immediate   (immediate),
        .instr_raw   (instr_raw),
        .range_err   (range_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Packed response: {valid, range_err, raw, format, opcode, sign, operand, immediate}
    function automatic logic [27:0] mk(input logic v, input logic r, input logic [8:0] w);
        return {v, r, w, w[8], w[7:4], w[3], w[2:0], w[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic le, input logic lb, input logic [5:0] la,
                         input logic [8:0] ldat, input logic fr, input logic bs,
                         input logic [15:0] pc, input logic st);
        @(negedge clk);
        load_en   = le;
        load_bank = lb;
        load_addr = la;
        load_data = ldat;
        fetch_req = fr;
        bank_sel  = bs;
        pc_in     = pc;
        stall     = st;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'd0, 9'h000, 1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic load(input logic lb, input logic [5:0] la, input logic [8:0] d);
        drive(1'b1, lb, la, d, 1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic fetch(input logic bs, input logic [15:0] pc, input logic [27:0] e);
        drive(1'b0, 1'b0, 6'd0, 9'h000, 1'b1, bs, pc, 1'b0);
        exp_q.push_back(e);
    endtask

    // Monitor: every edge that saw fetch_req high owes one response.
    initial begin
        logic        issue;
        logic [27:0] e, a;
        forever begin
            @(posedge clk);
            issue = rst_n && fetch_req;
            @(negedge clk);
            if (issue) begin
                a = {instr_valid, range_err, instr_raw, format, opcode, sign, operand, immediate};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL scoreboard: response 0x%0h with empty queue", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        n_err++;
                        $display("FAIL fetch_resp: got 0x%07h, expected 0x%07h", a, e);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        load_en = 1'b0; load_bank = 1'b0; load_addr = '0; load_data = '0;
        fetch_req = 1'b0; pc_in = '0; bank_sel = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_valid", 32'(instr_valid), 32'd0);
        check("reset_raw", 32'(instr_raw), 32'd0);
        check("reset_range", 32'(range_err), 32'd0);

        // Release reset with loads and fetches active: both must be ignored in CLEAR.
        @(negedge clk);
        rst_n = 1'b1;
        load_en = 1'b1; load_bank = 1'b1; load_addr = 6'd5; load_data = 9'h1FF;
        fetch_req = 1'b1; bank_sel = 1'b1; pc_in = 16'd5;
        n = 0;
        while (busy && n < 1000) begin
            exp_q.push_back(mk(1'b0, 1'b0, 9'h000));
            @(negedge clk);
            n++;
        end
        load_en = 1'b0;
        fetch_req = 1'b0;
        check("clear_cycles", 32'(n), 32'd128);

        fetch(1'b1, 16'd5, mk(1'b1, 1'b0, 9'h000));

        load(1'b0, 6'd3, 9'b101110001);
        fetch(1'b0, 16'd3, {1'b1, 1'b0, 9'h171, 1'b1, 4'b0111, 1'b0, 3'b001, 8'h71});
        idle();
        idle();
        check("idle_valid", 32'(instr_valid), 32'd0);
        check("idle_hold_raw", 32'(instr_raw), 32'h171);
        check("idle_hold_opcode", 32'(opcode), 32'h7);

        fetch(1'b0, 16'd64, mk(1'b1, 1'b1, 9'h000));
        idle();
        idle();
        check("range_one_cycle", 32'(range_err), 32'd0);
        check("range_idle_valid", 32'(instr_valid), 32'd0);

        // Stall holds outputs; a load during stall still lands.
        load(1'b0, 6'd0, 9'h0C3);
        load(1'b0, 6'd10, 9'h1FF);
        fetch(1'b0, 16'd10, mk(1'b1, 1'b0, 9'h1FF));
        drive(1'b0, 1'b0, 6'd0, 9'h000, 1'b1, 1'b0, 16'd0, 1'b1);
        exp_q.push_back(mk(1'b1, 1'b0, 9'h1FF));
        drive(1'b1, 1'b0, 6'd12, 9'h15A, 1'b1, 1'b0, 16'd0, 1'b1);
        exp_q.push_back(mk(1'b1, 1'b0, 9'h1FF));
        drive(1'b0, 1'b0, 6'd0, 9'h000, 1'b1, 1'b0, 16'd0, 1'b1);
        exp_q.push_back(mk(1'b1, 1'b0, 9'h1FF));
        drive(1'b0, 1'b0, 6'd0, 9'h000, 1'b1, 1'b0, 16'd64, 1'b1);
        exp_q.push_back(mk(1'b1, 1'b0, 9'h1FF));
        fetch(1'b0, 16'd0, mk(1'b1, 1'b0, 9'h0C3));
        fetch(1'b0, 16'd12, mk(1'b1, 1'b0, 9'h15A));

        // Same-cycle load and fetch of one location returns the old word.
        load(1'b0, 6'd7, 9'h055);
        drive(1'b1, 1'b0, 6'd7, 9'h0AA, 1'b1, 1'b0, 16'd7, 1'b0);
        exp_q.push_back(mk(1'b1, 1'b0, 9'h055));
        fetch(1'b0, 16'd7, mk(1'b1, 1'b0, 9'h0AA));

        load(1'b1, 6'd7, 9'h123);
        fetch(1'b1, 16'd7, mk(1'b1, 1'b0, 9'h123));
        fetch(1'b0, 16'd7, mk(1'b1, 1'b0, 9'h0AA));
        idle();

        // Reset from RUN, then again 40 words into the clear.
        #1;
        rst_n = 1'b0;
        #1;
        check("run_reset_busy", 32'(busy), 32'd1);
        check("run_reset_valid", 32'(instr_valid), 32'd0);
        check("run_reset_raw", 32'(instr_raw), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_clear_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_clear_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reclear_cycles", 32'(n), 32'd128);
        fetch(1'b0, 16'd7, mk(1'b1, 1'b0, 9'h000));
        idle();
        idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
